// File: rtl/axi_pkg.sv
// axi_pkg: AXI response codes, arbiter state encoding and pointer helper.
// Shared by axi_cmd_arbiter and rr_picker.
package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;

  // next round-robin start point, wrapping at n
  function automatic int unsigned rr_next(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_cmd_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search.
// First set req bit at or after ptr, wrapping past NUM_REQ-1.
module rr_picker
  import axi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    int c;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[IW'(c)]) begin
        idx = IW'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// axi_cmd_arbiter: round-robin N:1 command arbiter in front of axi_master.
// Optional per-requester grant counters: define AXI_CMD_ARB_STATS_EN.
module axi_cmd_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*(AXI_DATA_WIDTH/8)-1:0] req_wstrb,
  input  logic [NUM_REQ*8-1:0]                req_len,
  output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic [NUM_REQ-1:0]                  rsp_rvalid,
  input  logic [NUM_REQ-1:0]                  rsp_rready,
  output logic                                cmd_valid,
  input  logic                                cmd_ready,
  output logic                                cmd_write,
  output logic [AXI_ADDR_WIDTH-1:0]           cmd_addr,
  output logic [AXI_DATA_WIDTH-1:0]           cmd_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]         cmd_wstrb,
  output logic [7:0]                          cmd_len,
  input  logic [AXI_DATA_WIDTH-1:0]           cmd_rdata,
  input  logic [1:0]                          cmd_resp,
  input  logic                                cmd_rvalid,
  output logic                                cmd_rready,
  input  logic                                cmd_done,
  output logic [$clog2(NUM_REQ)-1:0]          grant_idx
`ifdef AXI_CMD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]               grant_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          cmd_write_q, cmd_write_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]    cmd_len_q, cmd_len_d;

  logic [IW-1:0] win_idx;
  logic          win_any;
  logic          win_write;
  logic [AW-1:0] win_addr;
  logic [7:0]    win_len;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;
  logic          sel_rready;

  logic st_idle, st_issue, st_busy, hs;

  assign st_idle  = (state_q == ARB_IDLE);
  assign st_issue = (state_q == ARB_ISSUE);
  assign st_busy  = (state_q == ARB_BUSY);
  assign hs       = st_issue && cmd_ready;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .idx(win_idx),
    .any(win_any)
  );

  // fields of the arbitration winner, latched on entry to ISSUE
  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win_idx) begin
        win_write = req_write[i];
        win_addr  = req_addr[i*AW +: AW];
        win_len   = req_len[i*8 +: 8];
      end
    end
  end

  always_comb begin
    sel_wdata  = '0;
    sel_wstrb  = '0;
    sel_rready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == grant_q) begin
        sel_wdata  = req_wdata[i*DW +: DW];
        sel_wstrb  = req_wstrb[i*SW +: SW];
        sel_rready = rsp_rready[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    unique case (1'b1)
      st_idle: begin
        if (win_any) begin
          state_d     = ARB_ISSUE;
          grant_d     = win_idx;
          cmd_write_d = win_write;
          cmd_addr_d  = win_addr;
          cmd_len_d   = win_len;
        end
      end
      st_issue: begin
        if (cmd_ready) begin
          state_d  = ARB_BUSY;
          rr_ptr_d = IW'(rr_next(32'(grant_q), NUM_REQ));
        end
      end
      st_busy: begin
        if (cmd_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  always_comb begin
    req_ready  = '0;
    rsp_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == grant_q) begin
        req_ready[i]  = hs;
        rsp_rvalid[i] = st_busy && cmd_rvalid;
      end
    end
  end

  assign cmd_valid  = st_issue;
  assign cmd_write  = cmd_write_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign cmd_wdata  = sel_wdata;
  assign cmd_wstrb  = sel_wstrb;
  assign cmd_rready = st_busy && sel_rready;
  assign rsp_rdata  = cmd_rdata;
  assign rsp_resp   = cmd_resp;
  assign grant_idx  = grant_q;

`ifdef AXI_CMD_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    cnt_d = cnt_q;
    if (hs && cnt_q[grant_q] != 16'hFFFF) begin
      cnt_d[grant_q] = cnt_q[grant_q] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: doc/axi_cmd_arbiter.md
AXI_CMD_ARBITER -- requirements
Module: axi_cmd_arbiter

Interface
- REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
- REQ-002 The block SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning the command address width.
- REQ-003 The block SHALL have parameter AXI_DATA_WIDTH, default 32, meaning the data width; STRB_WIDTH = AXI_DATA_WIDTH/8.
- REQ-004 The block SHALL have these ports:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - req_valid / req_ready  in / out  NUM_REQ  per-requester command handshake.
  - req_write  in  NUM_REQ  per-requester direction (1 = write).
  - req_addr / req_wdata  in  NUM_REQ x AXI_ADDR_WIDTH / NUM_REQ x AXI_DATA_WIDTH  packed per requester.
  - req_wstrb / req_len  in  NUM_REQ x STRB_WIDTH / NUM_REQ x 8  packed per requester.
  - rsp_rdata / rsp_resp  out  AXI_DATA_WIDTH / 2  shared read data and response.
  - rsp_rvalid / rsp_rready  out / in  NUM_REQ  per-requester read beat handshake.
  - cmd_valid / cmd_ready  out / in  1  command handshake to axi_master.
  - cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_len  out  1, AXI_ADDR_WIDTH, AXI_DATA_WIDTH, STRB_WIDTH, 8  command fields.
  - cmd_rdata / cmd_resp / cmd_rvalid  in  AXI_DATA_WIDTH / 2 / 1  read return from axi_master.
  - cmd_rready  out  1  read beat acceptance.
  - cmd_done  in  1  one-cycle pulse from axi_master when the transaction completes (B accepted, or last R beat accepted).
  - grant_idx  out  $clog2(NUM_REQ)  current owner index.

Function
- REQ-005 The FSM SHALL have states IDLE, ISSUE and BUSY.
- REQ-006 In IDLE with any req_valid set, the block SHALL pick a winner round-robin, starting the search at rr_ptr, latch it into grant_idx, and go to ISSUE the next cycle.
- REQ-007 In ISSUE the block SHALL drive cmd_valid=1 with the winner's fields and hold them stable until cmd_ready; on cmd_valid&&cmd_ready it SHALL assert req_ready[grant_idx] for that same cycle only, go to BUSY, and set rr_ptr = grant_idx+1, wrapping from NUM_REQ-1 to 0.
- REQ-008 In BUSY, cmd_wdata/cmd_wstrb SHALL combinationally follow req_wdata/req_wstrb of grant_idx.
- REQ-009 In BUSY the read path SHALL be combinational, with no added latency:
  - rsp_rvalid[grant_idx] = cmd_rvalid; all other rsp_rvalid bits = 0.
  - cmd_rready = rsp_rready[grant_idx].
  - rsp_rdata = cmd_rdata; rsp_resp = cmd_resp.
- REQ-010 cmd_done in BUSY SHALL return the FSM to IDLE the next cycle; arbitration latency from IDLE request to cmd_valid SHALL be 1 cycle.
- REQ-011 cmd_done outside BUSY SHALL be ignored.
- REQ-012 A req_valid deasserted while in ISSUE SHALL NOT cancel the command (requesters must hold valid until ready).
- REQ-013 Outside BUSY, cmd_rready SHALL be 0 and all rsp_rvalid bits SHALL be 0.
- REQ-014 When a single requester is continuously valid and others are idle, it SHALL be re-granted every transaction.
- REQ-015 With all requesters valid, grants SHALL rotate 0,1,2,3,0,...

Reset
- REQ-016 On rst_n low, asynchronously:
  - state = IDLE, rr_ptr = 0, grant_idx = 0.
  - cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_rready = 0.
  - all req_ready and rsp_rvalid bits = 0.
- REQ-017 Reset mid-transaction SHALL abandon the transaction with no recovery; the master is reset on the same rst_n.

Configuration
- REQ-018 With AXI_CMD_ARB_STATS_EN defined, the block SHALL add output grant_cnt (NUM_REQ x 16 bits), one counter per requester, behaving as follows:
  - incremented on that requester's cmd handshake;
  - saturating at 16'hFFFF;
  - reset to 0.
- REQ-019 Without AXI_CMD_ARB_STATS_EN, grant_cnt and its counters SHALL be absent.

Structure
- REQ-020 A shared package axi_pkg SHALL hold:
  - AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the arbiter state enum type.
- REQ-021 Round-robin selection SHALL be a sub-module rr_picker: combinational; inputs req vector and rr_ptr; outputs winner index and any-valid.

Verification
- REQ-022 Single requester: req1 write, addr 0x10, wdata 0xABCD1234, len 0 -> grant_idx=1; cmd_valid 1 cycle after req_valid; req_ready[1] pulses once; FSM returns to IDLE after cmd_done.
- REQ-023 All four requesters valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- REQ-024 Req2 read burst, addr 0x20, len 3, with rsp_rready[2] toggled 1,0,1,1,1 -> exactly 4 beats delivered in order on rsp_rvalid[2]; no rsp_rvalid on other requesters.
- REQ-025 cmd_ready held low 5 cycles in ISSUE -> cmd_addr/cmd_len/cmd_write stable throughout; req_ready stays 0 until the handshake.
- REQ-026 rst_n asserted during BUSY of a len-3 read -> all outputs at reset values immediately; the next request is granted from rr_ptr=0.
- REQ-027 With AXI_CMD_ARB_STATS_EN, 3 grants to req0 -> grant_cnt[0]=3 and the others 0; a counter preloaded to 0xFFFF stays 0xFFFF after a further grant.
